program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, the largest word count accepted in a header.
REQ-003 clock  input  1  the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 byte_in  input  8  serial program stream byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  the loader accepts byte_in this cycle.
REQ-009 mem_addr  output  64  instruction-memory byte address.
REQ-010 mem_data  output  32  instruction word to write.
REQ-011 mem_write  output  1  one-cycle write strobe for mem_addr/mem_data.
REQ-012 cpu_reset  output  1  holds the datapath in reset while high.
REQ-013 done  output  1  level; the load completed and the checksum matched.
REQ-014 error  output  1  level; the load was aborted.

Function
REQ-015 A byte is accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-016 Stream format: count low byte, count high byte (N, 16-bit little-endian), N words of 4 bytes each (little-endian), then one checksum byte.
REQ-017 The checksum byte equals the XOR of all 4N instruction bytes; it is 8'h00 when N=0.
REQ-018 States: IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-019 IDLE: start moves to CNT_LO; the word index and the running XOR are cleared.
REQ-020 CNT_LO moves to CNT_HI on an accepted byte.
REQ-021 CNT_HI on an accepted byte moves to ERROR if N > MAX_WORDS, to CHECK if N = 0, and otherwise to DATA.
REQ-022 DATA on each accepted byte shifts the byte into the word (first byte goes to bits 7:0) and folds it into the XOR.
REQ-023 DATA moves to WRITE after the 4th byte of a word is accepted.
REQ-024 WRITE lasts exactly one cycle: mem_write=1, mem_data holds the assembled word, and mem_addr = BASE_ADDR + 4*index.
REQ-025 On leaving WRITE, index is incremented; the next state is CHECK if index+1 = N, otherwise DATA.
REQ-026 Latency: the 4th byte accepted at edge t gives mem_write=1 in the cycle after t. Minimum throughput is 5 cycles per word.
REQ-027 CHECK on an accepted byte moves to DONE if the byte equals the XOR, otherwise to ERROR.
REQ-028 byte_ready is 1 only in CNT_LO, CNT_HI, DATA and CHECK; it is 0 in WRITE, IDLE, DONE and ERROR.
REQ-029 mem_write is 0 in every state except WRITE.
REQ-030 cpu_reset is 1 in every state except DONE; done=1 only in DONE; error=1 only in ERROR.
REQ-031 DONE and ERROR hold until start, which re-enters CNT_LO and raises cpu_reset again in the next cycle.
REQ-032 start is ignored in CNT_LO, CNT_HI, DATA, WRITE and CHECK.
REQ-033 The index counter is 16 bits wide. The address arithmetic is 64-bit; addresses beyond BASE_ADDR + 4*(MAX_WORDS-1) are never produced.

Reset
REQ-034 reset has priority over all other inputs and forces IDLE, index=0, XOR=0 and word=0.
REQ-035 Reset values of the outputs: byte_ready=0, mem_write=0, mem_addr=BASE_ADDR, mem_data=0, cpu_reset=1, done=0, error=0.
REQ-036 reset asserted mid-load (including during WRITE) aborts the load in the same edge, with no further mem_write.

Structure
REQ-037 The state encoding and the header/checksum byte counts belong in the shared package program_loader_pkg.
REQ-038 One sub-module, byte_assembler, is used; it holds the 4-byte shift register and the running XOR, with clear and load controls.

Verification
REQ-039 N=2, words 32'hF8000020 and 32'h8B020020, correct checksum, byte_valid always 1 -> two writes at addresses 0x0 and 0x4 with those data, exactly 5 cycles apart; then done=1 and cpu_reset=0.
REQ-040 N=0, checksum byte 8'h00 -> DONE with no mem_write; a checksum byte of 8'h01 instead -> ERROR with cpu_reset held at 1.
REQ-041 N=1 with a wrong checksum -> one mem_write, then error=1 and done=0.
REQ-042 Header N = MAX_WORDS+1 -> ERROR immediately after the count high byte is accepted; byte_ready=0 and no mem_write.
REQ-043 byte_valid toggled every other cycle, plus start pulsed mid-DATA -> the same writes as the gap-free case and the start pulse is ignored.
REQ-044 reset asserted during the WRITE of word 1 -> mem_write is 0 from the next cycle and the reset values of REQ-035 appear; a subsequent start and a full stream load correctly.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding, stream
// framing constants and the instruction-address helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int CHK_BYTES  = 1;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 16;

    function automatic logic [63:0] word_addr(input logic [63:0] base,
                                              input logic [IDX_W-1:0] idx);
        return base + {46'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 4-byte word shift register with a running XOR of every
// byte loaded since the last clear.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [7:0]              byte_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic [7:0]              xor_o
);

    logic [8*WORD_BYTES-1:0] word_q;
    logic [7:0]              xor_q;

    // New bytes enter at the top so the first byte of a word ends in bits 7:0.
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            word_q <= '0;
            xor_q  <= '0;
        end else if (load_i) begin
            word_q <= {byte_i, word_q[8*WORD_BYTES-1:8]};
            xor_q  <= xor_q ^ byte_i;
        end
    end

    assign word_o = word_q;
    assign xor_o  = xor_q;

endmodule

// File: rtl/program_loader.sv
// Parses a length-prefixed, XOR-checksummed byte stream into instruction
// memory writes and releases the CPU from reset once the image verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_write,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output state_t      dbg_state
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic               asm_clear, asm_load, accept;
    logic [IDX_W-1:0]   n_hdr;
    logic [31:0]        word;
    logic [7:0]         xor_acc;

    byte_assembler u_asm (
        .clock   (clock),
        .reset   (reset),
        .clear_i (asm_clear),
        .load_i  (asm_load),
        .byte_i  (byte_in),
        .word_o  (word),
        .xor_o   (xor_acc)
    );

    assign byte_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign n_hdr      = {byte_in, count_q[7:0]};
    assign mem_data   = word;
    assign dbg_state  = state_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        bcnt_d    = bcnt_q;
        asm_clear = 1'b0;
        asm_load  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = BASE_ADDR;
        cpu_reset = (state_q != S_DONE);
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_CNT_LO;
                    index_d   = '0;
                    bcnt_d    = '0;
                    asm_clear = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    count_d = {8'h00, byte_in};
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    count_d = n_hdr;
                    if (int'({16'b0, n_hdr}) > MAX_WORDS) state_d = S_ERROR;
                    else if (n_hdr == '0)                 state_d = S_CHECK;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_load = 1'b1;
                    bcnt_d   = bcnt_q + 2'd1;
                    if (bcnt_q == 2'(WORD_BYTES - 1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address is only driven here, so it never runs past the last word.
                mem_write = 1'b1;
                mem_addr  = word_addr(BASE_ADDR, index_q);
                index_d   = index_q + 16'd1;
                state_d   = (index_q + 16'd1 == count_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept) state_d = (byte_in == xor_acc) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            index_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a stream model builds the
// byte image and expected writes, a negedge monitor pops and compares them.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam logic [63:0] BASE = 64'h0;
    localparam int          MAXW = 1024;

    logic        clock = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready, mem_write, cpu_reset, done, error;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    state_t      dbg_state;

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_write(mem_write), .cpu_reset(cpu_reset),
        .done(done), .error(error), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] stim_words[$];
    int          wr_cyc_q[$];
    bit          abort = 1'b0;
    logic [63:0] mon_addr;
    logic [31:0] mon_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (mem_write === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_data);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                chk("write_addr", mem_addr, mon_addr);
                chk("write_data", 64'(mem_data), 64'(mon_data));
                chk("ready_in_write", 64'(byte_ready), 64'd0);
            end
        end
    end

    // driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        ok = 1'b0;
        if (gaps) begin
            byte_valid = 1'b0;
            @(negedge clock);
        end
        byte_in = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (abort) return;
            if (byte_ready) begin
                @(negedge clock);
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout actual=not_ready expected=ready");
    endtask

    task automatic check_end(input bit expect_done);
        chk("end_done", 64'(done), 64'(expect_done));
        chk("end_error", 64'(error), 64'(!expect_done));
        chk("end_cpu_reset", 64'(cpu_reset), 64'(!expect_done));
        chk("end_ready", 64'(byte_ready), 64'd0);
        chk("pending_writes", 64'(exp_addr_q.size()), 64'd0);
        repeat (3) @(negedge clock);
        chk("hold_done", 64'(done), 64'(expect_done));
    endtask

    // reference model: builds the byte image, expected writes and outcome
    task automatic run_load(input int n, input bit bad_chk, input bit gaps);
        logic [7:0]  bq[$];
        logic [7:0]  x;
        logic [15:0] n16;
        bit          ok;
        bit          over;
        x = 8'h00;
        n16 = 16'(n);
        over = (n > MAXW);
        bq.push_back(n16[7:0]);
        bq.push_back(n16[15:8]);
        if (!over) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    bq.push_back(stim_words[i][8*j +: 8]);
                    x ^= stim_words[i][8*j +: 8];
                end
                exp_addr_q.push_back(BASE + 64'(4 * i));
                exp_data_q.push_back(stim_words[i]);
            end
            bq.push_back(bad_chk ? (x ^ 8'h01) : x);
        end
        pulse_start();
        for (int b = 0; b < bq.size(); b++) begin
            send_byte(bq[b], gaps, ok);
            if (abort || !ok) break;
            if (!over && b >= 2 && b < bq.size() - 1 && ((b - 2) % 4) == 3)
                chk("write_latency", 64'(mem_write), 64'd1);
        end
        byte_valid = 1'b0;
        if (abort) return;
        if (over) begin
            chk("over_error", 64'(error), 64'd1);
            chk("over_done", 64'(done), 64'd0);
            chk("over_ready", 64'(byte_ready), 64'd0);
            chk("over_writes", 64'(exp_addr_q.size()), 64'd0);
            repeat (2) @(negedge clock);
        end else begin
            check_end(!bad_chk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, BASE);
        chk({tag, "_mem_data"}, 64'(mem_data), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic fill_random(input int n);
        stim_words.delete();
        for (int i = 0; i < n; i++) stim_words.push_back($urandom);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        // two known words, gap-free, writes exactly 5 cycles apart
        stim_words = '{32'hF8000020, 32'h8B020020};
        wr_cyc_q.delete();
        run_load(2, 1'b0, 1'b0);
        chk("two_word_write_count", 64'(wr_cyc_q.size()), 64'd2);
        if (wr_cyc_q.size() == 2)
            chk("write_spacing", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd5);

        // empty image: good and bad checksum
        stim_words.delete();
        run_load(0, 1'b0, 1'b0);
        run_load(0, 1'b1, 1'b0);

        // single word, bad checksum
        fill_random(1);
        run_load(1, 1'b1, 1'b0);

        // oversize header
        run_load(MAXW + 1, 1'b0, 1'b0);

        // gappy stream with a stray start pulse mid-DATA
        stim_words = '{32'hF8000020, 32'h8B020020};
        fork
            run_load(2, 1'b0, 1'b1);
            begin
                repeat (8) @(negedge clock);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        join

        // reset during the write of word 1, then a clean reload
        fill_random(3);
        fork
            run_load(3, 1'b0, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clock);
                    if (mem_write && mem_addr == BASE + 64'h4) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("reset_target_seen", 64'(seen), 64'd1);
                abort = 1'b1;
                reset = 1'b1;
                @(negedge clock);
                check_reset_values("midreset");
                @(negedge clock);
                chk("midreset_no_write", 64'(mem_write), 64'd0);
                reset = 1'b0;
                exp_addr_q.delete();
                exp_data_q.delete();
            end
        join
        abort = 1'b0;
        byte_valid = 1'b0;
        @(negedge clock);
        fill_random(3);
        run_load(3, 1'b0, 1'b0);

        // random images
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(0, 5);
            fill_random(n);
            run_load(n, ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
